wb_adapter: RTL and testbench
=============================

WB_ADAPTER -- requirements
Module: wb_adapter

Interface
REQ-001 Parameters (name, default, meaning):
- ADDR_WIDTH, 32, byte-address width on both sides.
- WBM_DATA_WIDTH, 32, master-side data width.
- WBM_SELECT_WIDTH, WBM_DATA_WIDTH/8, master-side select width.
- WBS_DATA_WIDTH, 32, slave-side data width.
- WBS_SELECT_WIDTH, WBS_DATA_WIDTH/8, slave-side select width.
REQ-002 The module SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, async active-low reset.
- wbm_adr_i, in, ADDR_WIDTH, master address.
- wbm_dat_i, in, WBM_DATA_WIDTH, master write data.
- wbm_dat_o, out, WBM_DATA_WIDTH, master read data.
- wbm_we_i, in, 1, write enable.
- wbm_sel_i, in, WBM_SELECT_WIDTH, byte selects.
- wbm_stb_i, in, 1, strobe.
- wbm_ack_o / wbm_err_o / wbm_rty_o, out, 1 each, terminations.
- wbm_cyc_i, in, 1, cycle.
- wbs_adr_o, out, ADDR_WIDTH, slave address.
- wbs_dat_i, in, WBS_DATA_WIDTH, slave read data.
- wbs_dat_o, out, WBS_DATA_WIDTH, slave write data.
- wbs_we_o, out, 1, write enable.
- wbs_sel_o, out, WBS_SELECT_WIDTH, byte selects.
- wbs_stb_o, out, 1, strobe.
- wbs_ack_i / wbs_err_i / wbs_rty_i, in, 1 each, terminations.
- wbs_cyc_o, out, 1, cycle.
REQ-004 Constraints: granularity (data width / select width) SHALL be equal on both sides, and the width ratio SHALL be a power of two. Legal cases: upsize, downsize, equal.

Function
REQ-005 All outputs SHALL be registered. FSM states: IDLE, WAIT_ACK.
REQ-006 IDLE start condition: wbm_cyc_i & wbm_stb_i & !wbm_ack_o/err_o/rty_o at an edge. On that edge the adapter latches the request, asserts wbs_cyc_o and wbs_stb_o, and enters WAIT_ACK.
REQ-007 Upsize (WBM narrower): exactly one slave access per master access. Address and lane rules:
- wbs_adr_o = wbm_adr_i with the low log2(WBS bytes) bits cleared.
- lane = wbm_adr_i[log2(WBS bytes)-1 : log2(WBM bytes)].
- wbs_sel_o = wbm_sel_i shifted to that lane; other bits 0.
- wbs_dat_o = wbm_dat_i replicated in all lanes.
- On ack, wbm_dat_o = the wbs_dat_i lane slice.
REQ-008 Downsize (WBM wider): one slave access per segment i (0..RATIO-1, ascending) whose select slice is nonzero. Per segment:
- wbs_adr_o = aligned master address + i*WBS bytes.
- wbs_sel_o and wbs_dat_o = slice i of the master sel/data.
- On ack, wbs_dat_i is stored into lane i of wbm_dat_o; unselected lanes read as 0.
If all select bits are 0, a single segment-0 access with sel 0 is performed.
REQ-009 Between downsize segments, wbs_cyc_o SHALL stay high and wbs_stb_o SHALL drop for exactly one cycle.
REQ-010 Equal widths: single pass-through access with the same timing.
REQ-011 Slave termination priority is err > rty > ack. wbs_ack_i on the final access pulses wbm_ack_o for exactly one cycle (with wbm_dat_o valid), deasserts wbs_cyc_o/wbs_stb_o on the same edge, and returns the FSM to IDLE.
REQ-012 wbs_err_i or wbs_rty_i on any access pulses wbm_err_o or wbm_rty_o respectively for one cycle. Remaining segments are abandoned, no wbm_ack_o is issued, and the FSM returns to IDLE.
REQ-013 wbm_cyc_i low while in WAIT_ACK (master abort): wbs_cyc_o/wbs_stb_o drop on the next edge, no master termination is issued, and the FSM returns to IDLE.
REQ-014 wbs_we_o SHALL equal the latched wbm_we_i for the whole transaction. A new transaction SHALL NOT start on the edge where a master termination is high.

Reset
REQ-015 While rst=0, all outputs SHALL be 0 and the FSM SHALL be in IDLE, regardless of any transaction in progress. Operation resumes on the first edge after release.

Verification
REQ-016 Upsize 8->32 write, adr 0x00000002, dat 0x5A, sel 1 -> wbs_adr_o 0x00000000, wbs_sel_o 0b0100, wbs_dat_o 0x5A5A5A5A, wbs_we_o 1. After wbs_ack_i, one wbm_ack_o pulse.
REQ-017 Upsize 8->32 read, adr 0x3; slave returns 0x11223344 -> wbm_dat_o 0x11 with the wbm_ack_o pulse.
REQ-018 Downsize 32->8 write, adr 0x100, sel 0b1010, dat 0xAABBCCDD -> two slave accesses:
- adr 0x101, dat 0xCC.
- adr 0x103, dat 0xAA.
Both with sel 1, and a single wbm_ack_o after the second.
REQ-019 Downsize 32->8 read, adr 0x200, sel 0xF; slave returns 0x01, 0x02, 0x03, 0x04 -> wbm_dat_o 0x04030201.
REQ-020 Downsize 32->8 with wbs_err_i on the second segment -> one wbm_err_o pulse, no wbm_ack_o, no third access.
REQ-021 rst asserted mid-transaction -> all outputs 0 immediately; a new access after release completes normally.

Source files
------------

// File: rtl/wb_adapter.sv
// Wishbone width adapter: one master port, one slave port, upsize/downsize/equal.
// Downsize accesses are split into per-segment slave accesses with a one-cycle strobe gap.
module wb_adapter #(
   parameter int ADDR_WIDTH       = 32,
   parameter int WBM_DATA_WIDTH   = 32,
   parameter int WBM_SELECT_WIDTH = WBM_DATA_WIDTH/8,
   parameter int WBS_DATA_WIDTH   = 32,
   parameter int WBS_SELECT_WIDTH = WBS_DATA_WIDTH/8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [ADDR_WIDTH-1:0]       wbm_adr_i,
   input  logic [WBM_DATA_WIDTH-1:0]   wbm_dat_i,
   output logic [WBM_DATA_WIDTH-1:0]   wbm_dat_o,
   input  logic                        wbm_we_i,
   input  logic [WBM_SELECT_WIDTH-1:0] wbm_sel_i,
   input  logic                        wbm_stb_i,
   output logic                        wbm_ack_o,
   output logic                        wbm_err_o,
   output logic                        wbm_rty_o,
   input  logic                        wbm_cyc_i,
   output logic [ADDR_WIDTH-1:0]       wbs_adr_o,
   input  logic [WBS_DATA_WIDTH-1:0]   wbs_dat_i,
   output logic [WBS_DATA_WIDTH-1:0]   wbs_dat_o,
   output logic                        wbs_we_o,
   output logic [WBS_SELECT_WIDTH-1:0] wbs_sel_o,
   output logic                        wbs_stb_o,
   input  logic                        wbs_ack_i,
   input  logic                        wbs_err_i,
   input  logic                        wbs_rty_i,
   output logic                        wbs_cyc_o
);

   localparam int MB    = WBM_SELECT_WIDTH;
   localparam int SB    = WBS_SELECT_WIDTH;
   localparam int RATIO = (MB > SB) ? MB/SB : SB/MB;
   localparam int SEG_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int S_LSB = $clog2(SB);

   typedef enum logic [0:0] {IDLE, WAIT_ACK} state_t;

   state_t                    state_q, state_d;
   logic [SEG_W-1:0]          seg_q, seg_d;
   logic [ADDR_WIDTH-1:0]     adr_q;
   logic [WBM_DATA_WIDTH-1:0] dat_q;
   logic [MB-1:0]             sel_q;
   logic                      latch, busy, start, s_ack, s_err, s_rty;

   logic [ADDR_WIDTH-1:0]     src_adr, seg_adr;
   logic [WBM_DATA_WIDTH-1:0] src_dat, rd_nxt;
   logic [MB-1:0]             src_sel;
   logic [SEG_W-1:0]          src_seg, first_seg, nxt_seg;
   logic                      has_nxt;
   logic [SB-1:0]             seg_sel;
   logic [WBS_DATA_WIDTH-1:0] seg_dat;

   logic [WBM_DATA_WIDTH-1:0] wbm_dat_d;
   logic                      wbm_ack_d, wbm_err_d, wbm_rty_d;
   logic [ADDR_WIDTH-1:0]     wbs_adr_d;
   logic [WBS_DATA_WIDTH-1:0] wbs_dat_d;
   logic [SB-1:0]             wbs_sel_d;
   logic                      wbs_we_d, wbs_stb_d, wbs_cyc_d;

   assign busy    = (state_q == WAIT_ACK);
   assign start   = wbm_cyc_i & wbm_stb_i & ~(wbm_ack_o | wbm_err_o | wbm_rty_o);
   assign s_err   = wbs_stb_o & wbs_err_i;
   assign s_rty   = wbs_stb_o & wbs_rty_i & ~wbs_err_i;
   assign s_ack   = wbs_stb_o & wbs_ack_i & ~wbs_err_i & ~wbs_rty_i;

   // In IDLE the slave request is built straight from the master inputs so it
   // can be registered on the same edge the request is latched.
   assign src_adr = busy ? adr_q   : wbm_adr_i;
   assign src_dat = busy ? dat_q   : wbm_dat_i;
   assign src_sel = busy ? sel_q   : wbm_sel_i;
   assign src_seg = busy ? nxt_seg : first_seg;

   generate
      if (MB < SB) begin : g_up
         localparam int M_LSB = $clog2(MB);
         // seg holds the slave lane the narrow master word maps onto
         always_comb begin
            first_seg = wbm_adr_i[S_LSB-1:M_LSB];
            nxt_seg   = seg_q;
            has_nxt   = 1'b0;
            seg_adr   = src_adr & ~ADDR_WIDTH'(SB-1);
            seg_sel   = SB'(src_sel) << (int'(src_seg) * MB);
            seg_dat   = {RATIO{src_dat}};
            rd_nxt    = wbs_dat_i[int'(seg_q)*WBM_DATA_WIDTH +: WBM_DATA_WIDTH];
         end
      end else begin : g_dn
         always_comb begin
            first_seg = '0;
            for (int i = RATIO-1; i >= 0; i--)
               if (wbm_sel_i[i*SB +: SB] != '0) first_seg = SEG_W'(i);
            nxt_seg = seg_q;
            has_nxt = 1'b0;
            for (int i = RATIO-1; i >= 0; i--)
               if (i > int'(seg_q) && sel_q[i*SB +: SB] != '0) begin
                  nxt_seg = SEG_W'(i);
                  has_nxt = 1'b1;
               end
            seg_adr = (src_adr & ~ADDR_WIDTH'(MB-1)) | (ADDR_WIDTH'(src_seg) << S_LSB)
                    | (src_adr & ADDR_WIDTH'(SB-1));
            seg_sel = src_sel[int'(src_seg)*SB +: SB];
            seg_dat = src_dat[int'(src_seg)*WBS_DATA_WIDTH +: WBS_DATA_WIDTH];
            rd_nxt  = wbm_dat_o;
            if (RATIO == 1 || sel_q[int'(seg_q)*SB +: SB] != '0)
               rd_nxt[int'(seg_q)*WBS_DATA_WIDTH +: WBS_DATA_WIDTH] = wbs_dat_i;
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         seg_q     <= '0;
         adr_q     <= '0;
         dat_q     <= '0;
         sel_q     <= '0;
         wbm_dat_o <= '0;
         wbm_ack_o <= 1'b0;
         wbm_err_o <= 1'b0;
         wbm_rty_o <= 1'b0;
         wbs_adr_o <= '0;
         wbs_dat_o <= '0;
         wbs_sel_o <= '0;
         wbs_we_o  <= 1'b0;
         wbs_stb_o <= 1'b0;
         wbs_cyc_o <= 1'b0;
      end else begin
         state_q   <= state_d;
         seg_q     <= seg_d;
         if (latch) begin
            adr_q <= wbm_adr_i;
            dat_q <= wbm_dat_i;
            sel_q <= wbm_sel_i;
         end
         wbm_dat_o <= wbm_dat_d;
         wbm_ack_o <= wbm_ack_d;
         wbm_err_o <= wbm_err_d;
         wbm_rty_o <= wbm_rty_d;
         wbs_adr_o <= wbs_adr_d;
         wbs_dat_o <= wbs_dat_d;
         wbs_sel_o <= wbs_sel_d;
         wbs_we_o  <= wbs_we_d;
         wbs_stb_o <= wbs_stb_d;
         wbs_cyc_o <= wbs_cyc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (start) state_d = WAIT_ACK;
         WAIT_ACK: if (!wbm_cyc_i || s_err || s_rty || (s_ack && !has_nxt)) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      latch     = 1'b0;
      seg_d     = seg_q;
      wbm_dat_d = wbm_dat_o;
      wbm_ack_d = 1'b0;
      wbm_err_d = 1'b0;
      wbm_rty_d = 1'b0;
      wbs_adr_d = wbs_adr_o;
      wbs_dat_d = wbs_dat_o;
      wbs_sel_d = wbs_sel_o;
      wbs_we_d  = wbs_we_o;
      wbs_stb_d = wbs_stb_o;
      wbs_cyc_d = wbs_cyc_o;
      case (state_q)
         IDLE: begin
            wbs_cyc_d = 1'b0;
            wbs_stb_d = 1'b0;
            if (start) begin
               latch     = 1'b1;
               seg_d     = first_seg;
               wbm_dat_d = '0;
               wbs_adr_d = seg_adr;
               wbs_dat_d = seg_dat;
               wbs_sel_d = seg_sel;
               wbs_we_d  = wbm_we_i;
               wbs_cyc_d = 1'b1;
               wbs_stb_d = 1'b1;
            end
         end
         WAIT_ACK: begin
            if (!wbm_cyc_i || s_err || s_rty) begin
               wbs_cyc_d = 1'b0;
               wbs_stb_d = 1'b0;
               wbm_err_d = wbm_cyc_i & s_err;
               wbm_rty_d = wbm_cyc_i & s_rty;
            end else if (s_ack) begin
               wbm_dat_d = rd_nxt;
               if (has_nxt) begin
                  // strobe gap before the next segment; cycle stays held
                  wbs_stb_d = 1'b0;
                  seg_d     = nxt_seg;
                  wbs_adr_d = seg_adr;
                  wbs_dat_d = seg_dat;
                  wbs_sel_d = seg_sel;
               end else begin
                  wbs_cyc_d = 1'b0;
                  wbs_stb_d = 1'b0;
                  wbm_ack_d = 1'b1;
               end
            end else if (!wbs_stb_o) begin
               wbs_stb_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_wb_adapter.sv
// Directed bench for wb_adapter: 8->32 upsize and 32->8 downsize instances.
module tb_wb_adapter;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // upsize instance: 8-bit master, 32-bit slave
   logic [31:0] mu_adr;
   logic [7:0]  mu_dat_w, mu_dat_r;
   logic        mu_we, mu_stb, mu_cyc, mu_ack, mu_err, mu_rty;
   logic [0:0]  mu_sel;
   logic [31:0] su_adr, su_dat_r, su_dat_w;
   logic [3:0]  su_sel;
   logic        su_we, su_stb, su_cyc, su_ack, su_err, su_rty;

   // downsize instance: 32-bit master, 8-bit slave
   logic [31:0] md_adr, md_dat_w, md_dat_r;
   logic [3:0]  md_sel;
   logic        md_we, md_stb, md_cyc, md_ack, md_err, md_rty;
   logic [31:0] sd_adr;
   logic [7:0]  sd_dat_r, sd_dat_w;
   logic [0:0]  sd_sel;
   logic        sd_we, sd_stb, sd_cyc, sd_ack, sd_err, sd_rty;

   wb_adapter #(.ADDR_WIDTH(32), .WBM_DATA_WIDTH(8), .WBS_DATA_WIDTH(32)) u_up (
      .clk(clk), .rst(rst),
      .wbm_adr_i(mu_adr), .wbm_dat_i(mu_dat_w), .wbm_dat_o(mu_dat_r), .wbm_we_i(mu_we),
      .wbm_sel_i(mu_sel), .wbm_stb_i(mu_stb), .wbm_ack_o(mu_ack), .wbm_err_o(mu_err),
      .wbm_rty_o(mu_rty), .wbm_cyc_i(mu_cyc),
      .wbs_adr_o(su_adr), .wbs_dat_i(su_dat_r), .wbs_dat_o(su_dat_w), .wbs_we_o(su_we),
      .wbs_sel_o(su_sel), .wbs_stb_o(su_stb), .wbs_ack_i(su_ack), .wbs_err_i(su_err),
      .wbs_rty_i(su_rty), .wbs_cyc_o(su_cyc));

   wb_adapter #(.ADDR_WIDTH(32), .WBM_DATA_WIDTH(32), .WBS_DATA_WIDTH(8)) u_dn (
      .clk(clk), .rst(rst),
      .wbm_adr_i(md_adr), .wbm_dat_i(md_dat_w), .wbm_dat_o(md_dat_r), .wbm_we_i(md_we),
      .wbm_sel_i(md_sel), .wbm_stb_i(md_stb), .wbm_ack_o(md_ack), .wbm_err_o(md_err),
      .wbm_rty_o(md_rty), .wbm_cyc_i(md_cyc),
      .wbs_adr_o(sd_adr), .wbs_dat_i(sd_dat_r), .wbs_dat_o(sd_dat_w), .wbs_we_o(sd_we),
      .wbs_sel_o(sd_sel), .wbs_stb_o(sd_stb), .wbs_ack_i(sd_ack), .wbs_err_i(sd_err),
      .wbs_rty_i(sd_rty), .wbs_cyc_o(sd_cyc));

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      mu_adr = '0; mu_dat_w = '0; mu_we = 0; mu_sel = '0; mu_stb = 0; mu_cyc = 0;
      su_dat_r = '0; su_ack = 0; su_err = 0; su_rty = 0;
      md_adr = '0; md_dat_w = '0; md_we = 0; md_sel = '0; md_stb = 0; md_cyc = 0;
      sd_dat_r = '0; sd_ack = 0; sd_err = 0; sd_rty = 0;

      #2;
      chk("rst_up", {mu_dat_r, mu_ack, mu_err, mu_rty, su_adr, su_dat_w, su_we, su_sel, su_stb, su_cyc}, '0);
      chk("rst_dn", {md_dat_r, md_ack, md_err, md_rty, sd_adr, sd_dat_w, sd_we, sd_sel, sd_stb, sd_cyc}, '0);
      step(); step();
      rst = 1'b1;

      // upsize write; master holds cyc/stb across the ack to check no restart
      mu_adr = 32'h2; mu_dat_w = 8'h5A; mu_sel = 1'b1; mu_we = 1; mu_cyc = 1; mu_stb = 1;
      step();
      chk("up_wr_req", {su_cyc, su_stb, su_we, su_adr, su_sel, su_dat_w, mu_ack},
          {1'b1, 1'b1, 1'b1, 32'h0, 4'b0100, 32'h5A5A5A5A, 1'b0});
      su_ack = 1;
      step();
      chk("up_wr_ack", {mu_ack, su_cyc, su_stb}, 3'b100);
      su_ack = 0;
      step();
      chk("up_no_restart", {mu_ack, su_cyc, su_stb}, 3'b000);
      mu_cyc = 0; mu_stb = 0;
      step();

      // upsize read from byte lane 3
      mu_adr = 32'h3; mu_we = 0; mu_sel = 1'b1; mu_cyc = 1; mu_stb = 1;
      step();
      chk("up_rd_req", {su_cyc, su_we, su_adr, su_sel}, {1'b1, 1'b0, 32'h0, 4'b1000});
      su_dat_r = 32'h11223344; su_ack = 1;
      step();
      chk("up_rd_ack", {mu_ack, mu_dat_r}, {1'b1, 8'h11});
      su_ack = 0; mu_cyc = 0; mu_stb = 0;
      step();
      chk("up_rd_pulse", mu_ack, 1'b0);

      // err beats rty beats ack
      mu_adr = 32'h0; mu_cyc = 1; mu_stb = 1;
      step();
      su_err = 1; su_rty = 1; su_ack = 1;
      step();
      chk("up_err_prio", {mu_err, mu_rty, mu_ack, su_cyc}, 4'b1000);
      su_err = 0; su_rty = 0; su_ack = 0; mu_cyc = 0; mu_stb = 0;
      step();
      mu_cyc = 1; mu_stb = 1;
      step();
      su_rty = 1; su_ack = 1;
      step();
      chk("up_rty_prio", {mu_err, mu_rty, mu_ack, su_cyc}, 4'b0100);
      su_rty = 0; su_ack = 0; mu_cyc = 0; mu_stb = 0;
      step();

      // master abort
      mu_cyc = 1; mu_stb = 1;
      step();
      chk("up_abort_req", su_cyc, 1'b1);
      mu_cyc = 0; mu_stb = 0;
      step();
      chk("up_abort", {su_cyc, su_stb, mu_ack, mu_err, mu_rty}, 5'b0);

      // downsize write, sel 1010 -> segments 1 and 3
      md_adr = 32'h100; md_sel = 4'b1010; md_dat_w = 32'hAABBCCDD; md_we = 1; md_cyc = 1; md_stb = 1;
      step();
      chk("dn_wr_seg1", {sd_cyc, sd_stb, sd_we, sd_adr, sd_sel, sd_dat_w},
          {1'b1, 1'b1, 1'b1, 32'h101, 1'b1, 8'hCC});
      sd_ack = 1;
      step();
      chk("dn_wr_gap", {sd_cyc, sd_stb, md_ack}, 3'b100);
      sd_ack = 0;
      step();
      chk("dn_wr_seg3", {sd_cyc, sd_stb, sd_adr, sd_sel, sd_dat_w}, {1'b1, 1'b1, 32'h103, 1'b1, 8'hAA});
      sd_ack = 1;
      step();
      chk("dn_wr_ack", {md_ack, sd_cyc, sd_stb}, 3'b100);
      sd_ack = 0; md_cyc = 0; md_stb = 0;
      step();
      chk("dn_wr_pulse", {md_ack, sd_cyc}, 2'b00);

      // downsize read, all four lanes
      md_adr = 32'h200; md_sel = 4'hF; md_we = 0; md_cyc = 1; md_stb = 1;
      step();
      for (int i = 0; i < 4; i++) begin
         chk("dn_rd_seg", {sd_stb, sd_we, sd_adr}, {1'b1, 1'b0, 32'h200 + i});
         sd_dat_r = 8'(i + 1); sd_ack = 1;
         step();
         sd_ack = 0;
         if (i < 3) begin
            chk("dn_rd_gap", {sd_cyc, sd_stb, md_ack}, 3'b100);
            step();
         end
      end
      chk("dn_rd_ack", {md_ack, md_dat_r}, {1'b1, 32'h04030201});
      md_cyc = 0; md_stb = 0;
      step();

      // error on second segment abandons the rest
      md_adr = 32'h300; md_sel = 4'hF; md_we = 1; md_dat_w = 32'h0; md_cyc = 1; md_stb = 1;
      step();
      sd_ack = 1;
      step();
      sd_ack = 0;
      step();
      chk("dn_err_seg2", {sd_stb, sd_adr}, {1'b1, 32'h301});
      sd_err = 1;
      step();
      chk("dn_err", {md_err, md_ack, sd_cyc, sd_stb}, 4'b1000);
      sd_err = 0; md_cyc = 0; md_stb = 0;
      step();
      step();
      chk("dn_err_after", {md_err, md_ack, sd_cyc, sd_stb}, 4'b0000);

      // all-zero select: single segment-0 access with sel 0
      md_adr = 32'h500; md_sel = 4'h0; md_dat_w = 32'h11223344; md_cyc = 1; md_stb = 1;
      step();
      chk("dn_sel0_req", {sd_stb, sd_adr, sd_sel, sd_dat_w}, {1'b1, 32'h500, 1'b0, 8'h44});
      sd_ack = 1;
      step();
      chk("dn_sel0_ack", {md_ack, sd_cyc}, 2'b10);
      sd_ack = 0; md_cyc = 0; md_stb = 0;
      step();

      // reset in the middle of a transaction
      md_adr = 32'h600; md_sel = 4'hF; md_dat_w = 32'hCAFEF00D; md_cyc = 1; md_stb = 1;
      step();
      chk("mid_req", {sd_cyc, sd_stb, sd_adr}, {1'b1, 1'b1, 32'h600});
      rst = 1'b0;
      #1;
      chk("mid_rst_dn", {md_dat_r, md_ack, md_err, md_rty, sd_adr, sd_dat_w, sd_we, sd_sel, sd_stb, sd_cyc}, '0);
      chk("mid_rst_up", {mu_dat_r, mu_ack, mu_err, mu_rty, su_adr, su_dat_w, su_we, su_sel, su_stb, su_cyc}, '0);
      md_adr = 32'h400; md_sel = 4'b0001; md_dat_w = 32'h12345678; md_we = 1;
      step();
      chk("mid_hold", {sd_cyc, sd_stb}, 2'b00);
      rst = 1'b1;
      step();
      chk("post_rst_req", {sd_stb, sd_adr, sd_sel, sd_dat_w}, {1'b1, 32'h400, 1'b1, 8'h78});
      sd_ack = 1;
      step();
      chk("post_rst_ack", {md_ack, sd_cyc}, 2'b10);
      sd_ack = 0; md_cyc = 0; md_stb = 0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
